// File: rtl/xgmii_rx_link_ctrl_32_if.sv
// xgmii_rx_link_ctrl_32_if: XGMII receive stream, enable request and link status bundle
interface xgmii_rx_link_ctrl_32_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] xgmii_rxd;
  logic [CTRL_WIDTH-1:0] xgmii_rxc;
  logic                  cfg_rx_enable_req;
  logic                  rx_enable;
  logic                  rx_in_frame;
  logic [1:0]            link_status;
  logic [1:0]            tx_fault_mode;
  logic                  fault_event;
  modport master (
    output xgmii_rxd, xgmii_rxc, cfg_rx_enable_req,
    input  rx_enable, rx_in_frame, link_status, tx_fault_mode, fault_event
  );
  modport slave (
    input  xgmii_rxd, xgmii_rxc, cfg_rx_enable_req,
    output rx_enable, rx_in_frame, link_status, tx_fault_mode, fault_event
  );
endinterface

// File: rtl/xgmii_rx_link_ctrl_32.sv
// xgmii_rx_link_ctrl_32: link fault detection and frame-aligned receive enable gating
module xgmii_rx_link_ctrl_32 #(
  parameter int DATA_WIDTH   = 32,
  parameter int CTRL_WIDTH   = DATA_WIDTH / 8,
  parameter int FAULT_COUNT  = 4,
  parameter int FAULT_WINDOW = 128
) (
  input logic                     clk,
  input logic                     rst,
  xgmii_rx_link_ctrl_32_if.slave  bus
);
  localparam int SW = $clog2(FAULT_COUNT + 1);
  localparam int CW = $clog2(FAULT_WINDOW + 1);
  typedef enum logic [1:0] {INIT, COUNT, FAULT} state_t;
  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] d0_rxd;
  logic [CTRL_WIDTH-1:0] d0_rxc;
  logic [1:0]            seq_type, seq_type_n, link_status, ls_n, tx_fault_mode, seq_t;
  logic [SW-1:0]         seq_cnt, seq_cnt_n, cnt_inc;
  logic [CW-1:0]         col_cnt, col_cnt_n;
  logic                  in_frame, rx_enable, rx_enable_n, fault_event;
  logic                  seq, start, same, expire, gate_open;
  assign seq_t     = d0_rxd[31:8] == 24'h010000 ? 2'b01 : d0_rxd[31:8] == 24'h020000 ? 2'b10 : 2'b00;
  assign seq       = d0_rxc == CTRL_WIDTH'(1) && d0_rxd[7:0] == 8'h9C && seq_t != 2'b00;
  assign start     = d0_rxc[0] && d0_rxd[7:0] == 8'hFB;
  assign same      = seq_t == seq_type;
  assign expire    = col_cnt == CW'(FAULT_WINDOW - 1);
  assign cnt_inc   = seq_cnt + SW'(1);
  assign gate_open = !in_frame && !start && link_status == 2'b00;
  // Fault sequence counting, window expiry and receive enable decision for the word in d0
  always_comb begin
    state_n    = state;
    seq_type_n = seq_type;
    seq_cnt_n  = seq_cnt;
    col_cnt_n  = col_cnt;
    ls_n       = link_status;
    if (seq && (state == INIT || !same)) begin
      seq_type_n = seq_t;
      seq_cnt_n  = SW'(1);
      col_cnt_n  = '0;
      state_n    = FAULT_COUNT == 1 ? FAULT : COUNT;
      ls_n       = FAULT_COUNT == 1 ? seq_t : link_status;
    end else if (seq) begin
      col_cnt_n = '0;
      if (state == COUNT) begin
        seq_cnt_n = cnt_inc;
        state_n   = cnt_inc == SW'(FAULT_COUNT) ? FAULT : COUNT;
        ls_n      = cnt_inc == SW'(FAULT_COUNT) ? seq_type : link_status;
      end
    end else if (state != INIT && expire) begin
      state_n   = INIT;
      seq_cnt_n = '0;
      col_cnt_n = '0;
      ls_n      = 2'b00;
    end else if (state != INIT) begin
      col_cnt_n = col_cnt + CW'(1);
    end
    rx_enable_n = ls_n != 2'b00 ? 1'b0 : gate_open ? bus.cfg_rx_enable_req : rx_enable;
  end
  // Input stage, fault state, frame tracking and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      d0_rxd        <= '0;
      d0_rxc        <= '0;
      state         <= INIT;
      seq_type      <= 2'b00;
      seq_cnt       <= '0;
      col_cnt       <= '0;
      link_status   <= 2'b00;
      fault_event   <= 1'b0;
      tx_fault_mode <= 2'b00;
      in_frame      <= 1'b0;
      rx_enable     <= 1'b0;
    end else begin
      d0_rxd        <= bus.xgmii_rxd;
      d0_rxc        <= bus.xgmii_rxc;
      state         <= state_n;
      seq_type      <= seq_type_n;
      seq_cnt       <= seq_cnt_n;
      col_cnt       <= col_cnt_n;
      link_status   <= ls_n;
      fault_event   <= ls_n != link_status;
      tx_fault_mode <= link_status == 2'b11 ? 2'b00 : link_status;
      in_frame      <= start ? 1'b1 : d0_rxc != '0 ? 1'b0 : in_frame;
      rx_enable     <= rx_enable_n;
    end
  end
  assign bus.rx_enable     = rx_enable;
  assign bus.rx_in_frame   = in_frame;
  assign bus.link_status   = link_status;
  assign bus.tx_fault_mode = tx_fault_mode;
  assign bus.fault_event   = fault_event;
endmodule

// File: doc/xgmii_rx_link_ctrl_32.md
Name: xgmii_rx_link_ctrl_32

Overview:
- Link-level controller in front of the 32-bit XGMII frame receiver.
- Monitors the same xgmii_rxd/xgmii_rxc stream for Clause-46-style local/remote fault sequence ordered sets and maintains link fault status.
- Drives the receiver's cfg_rx_enable, changing it only between frames and forcing it low while a fault is active.
- Tells the TX side what to transmit.

Parameters:
- DATA_WIDTH, 32, XGMII data width; only 32 supported.
- CTRL_WIDTH, DATA_WIDTH/8, XGMII control width.
- FAULT_COUNT, 4, same-type sequences needed to declare a fault.
- FAULT_WINDOW, 128, consecutive non-sequence words that clear count/fault.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- xgmii_rxd  input  DATA_WIDTH  XGMII receive data
- xgmii_rxc  input  CTRL_WIDTH  XGMII receive control
- cfg_rx_enable_req  input  1  software receive enable request
- rx_enable  output  1  to receiver cfg_rx_enable
- rx_in_frame  output  1  frame currently in progress (input register stage)
- link_status  output  2  00 ok, 01 local fault, 10 remote fault
- tx_fault_mode  output  2  00 normal, 01 send remote fault, 10 send idle
- fault_event  output  1  one-cycle pulse on any link_status change

Behaviour:
- Input stage: rxd/rxc registered once (d0); all decisions are made on d0.
- Decode on d0:
  - seq = rxc==4'b0001 && rxd[7:0]==8'h9C.
  - seq type local if rxd[31:8]==24'h010000; remote if rxd[31:8]==24'h020000.
  - Other 0x9C words are treated as non-sequence.
  - start = rxc[0] && rxd[7:0]==8'hFB.
- in_frame: set on a start word; cleared on any word with rxc!=0 that is not a start word (terminate, error, idle, sequence).
- Fault FSM states INIT, COUNT, FAULT; registers seq_type, seq_cnt (0..FAULT_COUNT), col_cnt (0..FAULT_WINDOW-1).
- INIT:
  - fault seq -> seq_type=type, seq_cnt=1, col_cnt=0, go COUNT.
  - If FAULT_COUNT==1, go FAULT directly.
- COUNT:
  - Same-type seq: seq_cnt+1, col_cnt=0; when seq_cnt+1==FAULT_COUNT, go FAULT and set link_status=type.
  - Other-type seq: restart with new type, seq_cnt=1.
  - Non-seq word: col_cnt+1; on the FAULT_WINDOW-th consecutive non-seq word, go INIT.
- FAULT:
  - Same-type seq: col_cnt=0.
  - Other-type seq: seq_type=new, seq_cnt=1, go COUNT; link_status keeps the old fault until the new type is confirmed or the window expires.
  - FAULT_WINDOW-th consecutive non-seq word: go INIT, link_status=00.
- Whenever the FSM is in COUNT and the window expires, link_status=00.
- Latency: link_status updates on the clock edge after the deciding word is in d0, i.e. visible 2 cycles after that word is on the xgmii inputs. fault_event is high in that same cycle only.
- tx_fault_mode: registered decode of link_status (01->01, 10->10, 00->00), one cycle after link_status.
- Gating: gate_open = !in_frame && !start(d0) && link_status==00.
  - When gate_open: rx_enable_next = cfg_rx_enable_req. Otherwise rx_enable holds, except that it is forced 0 when link_status!=00.
  - A fault mid-frame drops rx_enable immediately; the receiver is unaffected until its next start check.
  - rx_enable is stable from the cycle a start word enters d0 until the cycle after the closing control word leaves d0.
- Simultaneous events:
  - A sequence word both ends in_frame and counts toward the fault.
  - Request change and fault in the same cycle: the fault wins (0).
- Reset (rst): FSM INIT, counters 0, in_frame 0, rx_enable 0, link_status 00, tx_fault_mode 00, fault_event 0, d0 registers cleared. Reset mid-fault clears everything in one cycle.

Test Plan:
- Idle words rxd=0x07070707 rxc=0xF, req=1 after reset -> rx_enable=1 two cycles later; link_status=00; no fault_event.
- Four words 0x0100009C rxc=0x1, each separated by 10 idle words -> after the 4th: link_status=01, single fault_event pulse, tx_fault_mode=01 one cycle later, rx_enable=0.
- From that state, 128 idle words -> link_status=00 two cycles after the 128th word, fault_event pulse, rx_enable returns to 1 (req=1).
- Three local sequences, 128 idle words, three more sequences -> link_status stays 00; fault_event never asserted.
- req dropped during a frame (0x555555FB/0x1, 20 data words rxc=0, 0x070707FD/0xF) -> rx_enable stays 1 through the frame and falls once the terminate word has passed d0.
- Confirmed local fault, then four 0x0200009C sequences -> link_status goes 01->10 after the 4th remote sequence, tx_fault_mode=10; assert rst mid-sequence -> all outputs at reset values the next cycle.
